// File: rtl/jt1943_objdma_pkg.sv
// Shared definitions for the 1943 object DMA: FSM encoding, default geometry
// and the source-address helper.
package jt1943_objdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COPY = 2'd2,
        ST_DONE = 2'd3
    } objdma_state_e;

    localparam int          OBJ_AW_DEF   = 9;
    localparam logic [12:0] OBJ_BASE_DEF = 13'h1000;

    // CPU RAM is 13 bits wide, so the source address wraps naturally.
    function automatic logic [12:0] obj_src_addr(input logic [12:0] base,
                                                 input logic [12:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/jt1943_objdma_if.sv
// Bus between the object DMA (master) and the main CPU RAM side (slave).
interface jt1943_objdma_if;
    logic        bus_req;
    logic        bus_ack;
    logic        blcnten;
    logic [12:0] obj_AB;
    logic [7:0]  ram_dout;

    modport master (output bus_req, blcnten, obj_AB, input bus_ack, ram_dout);
    modport slave  (input bus_req, blcnten, obj_AB, output bus_ack, ram_dout);
endinterface

// File: rtl/jt1943_objdma_objbuf.sv
// Double-buffered object line buffer: two banks of 2**AW bytes, one write port
// for the DMA and one registered read port for the renderer.
module jt1943_objdma_objbuf #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW:0]   raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem [2**(AW+1)];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/jt1943_objdma.sv
// Object DMA: on vertical blank, takes the CPU bus and copies object RAM into
// the back bank of the line buffer, swapping banks only on a complete copy.
//  state | meaning
//  IDLE  | waiting for LVBL falling edge
//  REQ   | bus_req high, waiting for bus_ack
//  COPY  | blcnten high, reading CPU RAM and writing back bank
//  DONE  | copy finished, banks swapped, bus released
module jt1943_objdma
    import jt1943_objdma_pkg::*;
#(
    parameter int          AW   = OBJ_AW_DEF,
    parameter logic [12:0] BASE = OBJ_BASE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen_i,
    input  logic                    lvbl_i,
    jt1943_objdma_if.master         bus,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [7:0]              rd_data_o,
    output logic                    busy_o,
    output logic                    frame_ok_o
);
    localparam logic [AW:0] IDX_TC  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    objdma_state_e state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wvld_q, wvld_d;
    logic          front_q, front_d;
    logic          bus_req_q, bus_req_d;
    logic          blcnten_q, blcnten_d;
    logic          busy_q, busy_d;
    logic          frame_ok_q, frame_ok_d;
    logic          lvbl_q, lvbl_d;
    logic          we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            waddr_q    <= '0;
            wvld_q     <= 1'b0;
            front_q    <= 1'b0;
            bus_req_q  <= 1'b0;
            blcnten_q  <= 1'b0;
            busy_q     <= 1'b0;
            frame_ok_q <= 1'b0;
            lvbl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            waddr_q    <= waddr_d;
            wvld_q     <= wvld_d;
            front_q    <= front_d;
            bus_req_q  <= bus_req_d;
            blcnten_q  <= blcnten_d;
            busy_q     <= busy_d;
            frame_ok_q <= frame_ok_d;
            lvbl_q     <= lvbl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        waddr_d    = waddr_q;
        wvld_d     = wvld_q;
        front_d    = front_q;
        bus_req_d  = bus_req_q;
        blcnten_d  = blcnten_q;
        busy_d     = busy_q;
        frame_ok_d = 1'b0;
        lvbl_d     = lvbl_q;
        we         = 1'b0;
        if (cen_i) begin
            lvbl_d = lvbl_i;
            case (state_q)
                ST_IDLE: begin
                    if (lvbl_q && !lvbl_i) begin
                        state_d   = ST_REQ;
                        bus_req_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                ST_REQ: begin
                    // End of vblank wins over a late ack on the same cen.
                    if (lvbl_i) begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                        busy_d    = 1'b0;
                    end else if (bus.bus_ack) begin
                        state_d   = ST_COPY;
                        blcnten_d = 1'b1;
                        idx_d     = '0;
                        wvld_d    = 1'b0;
                    end
                end
                ST_COPY: begin
                    if (lvbl_i || !bus.bus_ack) begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                        blcnten_d = 1'b0;
                        busy_d    = 1'b0;
                        idx_d     = '0;
                    end else begin
                        we      = wvld_q;
                        waddr_d = idx_q[AW-1:0];
                        wvld_d  = 1'b1;
                        if (idx_q == IDX_TC) begin
                            state_d    = ST_DONE;
                            bus_req_d  = 1'b0;
                            blcnten_d  = 1'b0;
                            busy_d     = 1'b0;
                            front_d    = ~front_q;
                            frame_ok_d = 1'b1;
                            idx_d      = '0;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.bus_req = bus_req_q;
    assign bus.blcnten = blcnten_q;
    assign bus.obj_AB  = obj_src_addr(BASE, 13'(idx_q));
    assign busy_o      = busy_q;
    assign frame_ok_o  = frame_ok_q;

    // A write coinciding with reset would land in what becomes the front bank.
    jt1943_objdma_objbuf #(.AW(AW)) u_objbuf (
        .clk     (clk),
        .we_i    (we & ~rst),
        .waddr_i ({~front_q, waddr_q}),
        .wdata_i (bus.ram_dout),
        .raddr_i ({front_q, rd_addr_i}),
        .rdata_o (rd_data_o)
    );
endmodule
